err_monitor: RTL and testbench
==============================

ERR_MONITOR -- requirements
Module: err_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of word/bit/symbol counters (legal 8..32).
REQ-002 SHALL have parameter FLAG_CNT_W, default 16, width of disparity/control-flag counters.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port en  input  1  sample strobe; inputs below are valid when high.
REQ-006 SHALL have port clear  input  1  synchronous counter clear and pipeline flush.
REQ-007 SHALL have ports dout_original, dout_corrupted  input  80  encoded words, eight 10-bit symbols, symbol k = bits [10k+9:10k].
REQ-008 SHALL have ports disp_err_original, disp_err_corrupted, kin_err_original, kin_err_corrupted  input  1  encoder flags.
REQ-009 SHALL have ports word_cnt, word_err_cnt, sym_err_cnt, bit_err_cnt  output  CNT_W  accumulated statistics.
REQ-010 SHALL have ports disp_det_cnt, kin_det_cnt  output  FLAG_CNT_W  injected-error detections.
REQ-011 SHALL have port err_pulse  output  1  one-cycle strobe when a counted word had any mismatch.
REQ-012 SHALL have port busy  output  1  high while any pipeline stage holds a valid word.

Function
REQ-013 SHALL be a 3-stage pipeline: edge N registers inputs when en=1 (S1); edge N+1 registers XOR diff, per-symbol popcounts, flags (S2); edge N+2 updates counters and err_pulse.
REQ-014 SHALL accept one word per cycle with no backpressure; en every cycle is legal.
REQ-015 word_cnt SHALL increment by 1 per accepted word.
REQ-016 bit_err_cnt SHALL increase by popcount(dout_original ^ dout_corrupted), 0..80.
REQ-017 sym_err_cnt SHALL increase by number of symbols with any differing bit, 0..8.
REQ-018 word_err_cnt SHALL increment when diff is nonzero; err_pulse SHALL be high in that same cycle only.
REQ-019 disp_det_cnt SHALL increment when disp_err_corrupted=1 and disp_err_original=0; kin_det_cnt likewise for kin flags.
REQ-020 All counters SHALL saturate at all-ones; an addition that would overflow SHALL yield all-ones.
REQ-021 clear=1 SHALL zero all counters, invalidate S1/S2, drop en in that cycle, deassert err_pulse next cycle.
REQ-022 busy SHALL equal OR of S1 and S2 valid bits.

Reset
REQ-023 rst=1 SHALL asynchronously zero all counters, err_pulse, busy, valid bits and capture registers.
REQ-024 rst asserted mid-pipeline SHALL discard in-flight words; none counted after release.
REQ-025 First accepted word after rst release SHALL be sampled on the first rising edge with en=1.

Configuration
REQ-026 With ERR_MON_CAPTURE_EN defined, SHALL add outputs first_err_valid (1), first_err_idx (CNT_W), first_err_diff (80).
REQ-027 With ERR_MON_CAPTURE_EN, first erroneous word SHALL latch its word_cnt index (0-based) and XOR diff; later errors SHALL not overwrite until rst or clear.
REQ-028 Without ERR_MON_CAPTURE_EN, those ports and registers SHALL not exist; other behaviour identical.

Structure
REQ-029 Package err_mon_pkg SHALL hold SYM_W=10, N_SYM=8, WORD_W=80, and a saturating-add function.
REQ-030 Sub-module sym_popcount SHALL compute 4-bit popcount of one 10-bit symbol; eight instances in S2.

Verification
REQ-031 Equal words 80'h0 both inputs, flags 0, one en pulse -> word_cnt=1, all error counts 0, err_pulse never high.
REQ-032 original=0, corrupted=80'h1 -> bit_err_cnt=1, sym_err_cnt=1, word_err_cnt=1, err_pulse high exactly at edge N+2.
REQ-033 original=0, corrupted=all-ones, en 3 consecutive cycles -> bit_err_cnt=240, sym_err_cnt=24, word_err_cnt=3.
REQ-034 CNT_W=8, 4 all-ones-diff words -> bit_err_cnt=255 (saturated), word_cnt=4.
REQ-035 clear asserted one cycle after an erroneous en pulse -> all counters 0, err_pulse never high, busy low next cycle.
REQ-036 ERR_MON_CAPTURE_EN, words 0..2 with errors at idx 1 (diff 80'h300) and idx 2 -> first_err_idx=1, first_err_diff=80'h300.

Source files
------------

// File: rtl/err_mon_pkg.sv
// Shared word geometry and the saturating adder used by all statistics counters.
package err_mon_pkg;
    localparam int SYM_W  = 10;
    localparam int N_SYM  = 8;
    localparam int WORD_W = SYM_W * N_SYM;

    // Adds a+b and clamps to the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction
endpackage

// File: rtl/sym_popcount.sv
// Number of set bits in one 10-bit symbol; purely combinational.
module sym_popcount
    import err_mon_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    output logic [3:0]       o_cnt
);
    always_comb begin
        o_cnt = 4'd0;
        for (int k = 0; k < SYM_W; k++) begin
            o_cnt = o_cnt + 4'(i_sym[k]);
        end
    end
endmodule

// File: rtl/err_monitor.sv
// Bit/symbol/word error statistics between original and corrupted encoder words; 3-edge latency, one word per cycle, no backpressure.
// Defining ERR_MON_CAPTURE_EN adds capture of the first erroneous word's index and XOR diff.
module err_monitor
    import err_mon_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int FLAG_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [WORD_W-1:0]     dout_original,
    input  logic [WORD_W-1:0]     dout_corrupted,
    input  logic                  disp_err_original,
    input  logic                  disp_err_corrupted,
    input  logic                  kin_err_original,
    input  logic                  kin_err_corrupted,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [CNT_W-1:0]      word_err_cnt,
    output logic [CNT_W-1:0]      sym_err_cnt,
    output logic [CNT_W-1:0]      bit_err_cnt,
    output logic [FLAG_CNT_W-1:0] disp_det_cnt,
    output logic [FLAG_CNT_W-1:0] kin_det_cnt,
    output logic                  err_pulse,
`ifdef ERR_MON_CAPTURE_EN
    output logic                  first_err_valid,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [WORD_W-1:0]     first_err_diff,
`endif
    output logic                  busy
);
    logic                        r_s1_vld;
    logic [WORD_W-1:0]           r_s1_orig;
    logic [WORD_W-1:0]           r_s1_corr;
    logic                        r_s1_disp_o, r_s1_disp_c, r_s1_kin_o, r_s1_kin_c;
    logic [WORD_W-1:0]           w_s1_diff;
    logic [N_SYM-1:0][3:0]       w_sym_pop;

    logic                        r_s2_vld;
    logic [WORD_W-1:0]           r_s2_diff;
    logic [N_SYM-1:0][3:0]       r_s2_pop;
    logic                        r_s2_disp_det, r_s2_kin_det;

    logic [6:0]                  w_bit_sum;
    logic [3:0]                  w_sym_sum;
    logic                        w_word_err;

    logic [CNT_W-1:0]            r_word_cnt, r_word_err_cnt, r_sym_err_cnt, r_bit_err_cnt;
    logic [FLAG_CNT_W-1:0]       r_disp_det_cnt, r_kin_det_cnt;
    logic                        r_err_pulse;

    // S1: raw capture; clear takes priority over en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_orig   <= '0;
            r_s1_corr   <= '0;
            r_s1_disp_o <= 1'b0;
            r_s1_disp_c <= 1'b0;
            r_s1_kin_o  <= 1'b0;
            r_s1_kin_c  <= 1'b0;
        end else if (clear) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= en;
            if (en) begin
                r_s1_orig   <= dout_original;
                r_s1_corr   <= dout_corrupted;
                r_s1_disp_o <= disp_err_original;
                r_s1_disp_c <= disp_err_corrupted;
                r_s1_kin_o  <= kin_err_original;
                r_s1_kin_c  <= kin_err_corrupted;
            end
        end
    end

    assign w_s1_diff = r_s1_orig ^ r_s1_corr;

    for (genvar g = 0; g < N_SYM; g++) begin : g_pop
        sym_popcount u_pop (
            .i_sym (w_s1_diff[g*SYM_W +: SYM_W]),
            .o_cnt (w_sym_pop[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld      <= 1'b0;
            r_s2_diff     <= '0;
            r_s2_pop      <= '0;
            r_s2_disp_det <= 1'b0;
            r_s2_kin_det  <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld & ~clear;
            if (r_s1_vld) begin
                r_s2_diff     <= w_s1_diff;
                r_s2_pop      <= w_sym_pop;
                r_s2_disp_det <= r_s1_disp_c & ~r_s1_disp_o;
                r_s2_kin_det  <= r_s1_kin_c & ~r_s1_kin_o;
            end
        end
    end

    always_comb begin
        w_bit_sum = 7'd0;
        w_sym_sum = 4'd0;
        for (int k = 0; k < N_SYM; k++) begin
            w_bit_sum = w_bit_sum + 7'(r_s2_pop[k]);
            w_sym_sum = w_sym_sum + 4'(r_s2_pop[k] != 4'd0);
        end
    end

    assign w_word_err = |r_s2_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt     <= '0;
            r_word_err_cnt <= '0;
            r_sym_err_cnt  <= '0;
            r_bit_err_cnt  <= '0;
            r_disp_det_cnt <= '0;
            r_kin_det_cnt  <= '0;
            r_err_pulse    <= 1'b0;
        end else if (clear) begin
            r_word_cnt     <= '0;
            r_word_err_cnt <= '0;
            r_sym_err_cnt  <= '0;
            r_bit_err_cnt  <= '0;
            r_disp_det_cnt <= '0;
            r_kin_det_cnt  <= '0;
            r_err_pulse    <= 1'b0;
        end else begin
            r_err_pulse <= r_s2_vld & w_word_err;
            if (r_s2_vld) begin
                r_word_cnt     <= CNT_W'(sat_add(32'(r_word_cnt), 32'd1, CNT_W));
                r_word_err_cnt <= CNT_W'(sat_add(32'(r_word_err_cnt), 32'(w_word_err), CNT_W));
                r_sym_err_cnt  <= CNT_W'(sat_add(32'(r_sym_err_cnt), 32'(w_sym_sum), CNT_W));
                r_bit_err_cnt  <= CNT_W'(sat_add(32'(r_bit_err_cnt), 32'(w_bit_sum), CNT_W));
                r_disp_det_cnt <= FLAG_CNT_W'(sat_add(32'(r_disp_det_cnt), 32'(r_s2_disp_det), FLAG_CNT_W));
                r_kin_det_cnt  <= FLAG_CNT_W'(sat_add(32'(r_kin_det_cnt), 32'(r_s2_kin_det), FLAG_CNT_W));
            end
        end
    end

`ifdef ERR_MON_CAPTURE_EN
    logic                r_first_vld;
    logic [CNT_W-1:0]    r_first_idx;
    logic [WORD_W-1:0]   r_first_diff;

    // Index is the pre-increment word count, i.e. the 0-based position of the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_vld  <= 1'b0;
            r_first_idx  <= '0;
            r_first_diff <= '0;
        end else if (clear) begin
            r_first_vld  <= 1'b0;
            r_first_idx  <= '0;
            r_first_diff <= '0;
        end else if (r_s2_vld && w_word_err && !r_first_vld) begin
            r_first_vld  <= 1'b1;
            r_first_idx  <= r_word_cnt;
            r_first_diff <= r_s2_diff;
        end
    end

    assign first_err_valid = r_first_vld;
    assign first_err_idx   = r_first_idx;
    assign first_err_diff  = r_first_diff;
`endif

    assign word_cnt     = r_word_cnt;
    assign word_err_cnt = r_word_err_cnt;
    assign sym_err_cnt  = r_sym_err_cnt;
    assign bit_err_cnt  = r_bit_err_cnt;
    assign disp_det_cnt = r_disp_det_cnt;
    assign kin_det_cnt  = r_kin_det_cnt;
    assign err_pulse    = r_err_pulse;
    assign busy         = r_s1_vld | r_s2_vld;
endmodule

// File: tb/tb_err_monitor.sv
// Randomised and directed bench for err_monitor (default and 8-bit counter builds) against a scoreboard model.
module tb_err_monitor;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, clear;
    logic [79:0] d_orig, d_corr;
    logic        disp_o, disp_c, kin_o, kin_c;

    logic [31:0] wc, wec, sec, bec;
    logic [15:0] ddc, kdc;
    logic        ep, bz;
    logic [7:0]  wc8, wec8, sec8, bec8, ddc8, kdc8;
    logic        ep8, bz8;
`ifdef ERR_MON_CAPTURE_EN
    logic        fv, fv8;
    logic [31:0] fidx;
    logic [7:0]  fidx8;
    logic [79:0] fdiff, fdiff8;
`endif

    err_monitor dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .dout_original(d_orig), .dout_corrupted(d_corr),
        .disp_err_original(disp_o), .disp_err_corrupted(disp_c),
        .kin_err_original(kin_o), .kin_err_corrupted(kin_c),
        .word_cnt(wc), .word_err_cnt(wec), .sym_err_cnt(sec), .bit_err_cnt(bec),
        .disp_det_cnt(ddc), .kin_det_cnt(kdc), .err_pulse(ep),
`ifdef ERR_MON_CAPTURE_EN
        .first_err_valid(fv), .first_err_idx(fidx), .first_err_diff(fdiff),
`endif
        .busy(bz)
    );

    err_monitor #(.CNT_W(8), .FLAG_CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .dout_original(d_orig), .dout_corrupted(d_corr),
        .disp_err_original(disp_o), .disp_err_corrupted(disp_c),
        .kin_err_original(kin_o), .kin_err_corrupted(kin_c),
        .word_cnt(wc8), .word_err_cnt(wec8), .sym_err_cnt(sec8), .bit_err_cnt(bec8),
        .disp_det_cnt(ddc8), .kin_det_cnt(kdc8), .err_pulse(ep8),
`ifdef ERR_MON_CAPTURE_EN
        .first_err_valid(fv8), .first_err_idx(fidx8), .first_err_diff(fdiff8),
`endif
        .busy(bz8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each accepted word is due for counting two edges after acceptance.
    typedef struct {
        int          due;
        int          bits;
        int          syms;
        bit          err;
        bit          dd;
        bit          kd;
        logic [79:0] diff;
    } item_t;

    item_t       pend[$];
    int          edge_no = 0;
    longint      m_words, m_werr, m_sym, m_bit, m_disp, m_kin;
    bit          m_pulse;
    bit          m_cap_vld;
    longint      m_cap_idx;
    logic [79:0] m_cap_diff;

    function automatic longint satv(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_flush();
        m_words = 0; m_werr = 0; m_sym = 0; m_bit = 0; m_disp = 0; m_kin = 0;
        m_pulse = 0; m_cap_vld = 0; m_cap_idx = 0; m_cap_diff = '0;
        pend.delete();
    endtask

    task automatic model_edge();
        item_t it;
        edge_no++;
        m_pulse = 0;
        if (clear) begin
            model_flush();
        end else begin
            while (pend.size() > 0 && pend[0].due == edge_no) begin
                it = pend.pop_front();
                if (it.err && !m_cap_vld) begin
                    m_cap_vld = 1; m_cap_idx = m_words; m_cap_diff = it.diff;
                end
                m_words++;
                m_werr += it.err ? 1 : 0;
                m_sym  += it.syms;
                m_bit  += it.bits;
                m_disp += it.dd ? 1 : 0;
                m_kin  += it.kd ? 1 : 0;
                m_pulse = it.err;
            end
            if (en) begin
                it.diff = d_orig ^ d_corr;
                it.due  = edge_no + 2;
                it.bits = $countones(it.diff);
                it.syms = 0;
                for (int k = 0; k < 8; k++) if (it.diff[k*10 +: 10] != 10'd0) it.syms++;
                it.err  = (it.diff != '0);
                it.dd   = disp_c & ~disp_o;
                it.kd   = kin_c & ~kin_o;
                pend.push_back(it);
            end
        end
    endtask

    task automatic check_all();
        chk("word_cnt",     80'(wc),   80'(satv(m_words, 32)));
        chk("word_err_cnt", 80'(wec),  80'(satv(m_werr, 32)));
        chk("sym_err_cnt",  80'(sec),  80'(satv(m_sym, 32)));
        chk("bit_err_cnt",  80'(bec),  80'(satv(m_bit, 32)));
        chk("disp_det_cnt", 80'(ddc),  80'(satv(m_disp, 16)));
        chk("kin_det_cnt",  80'(kdc),  80'(satv(m_kin, 16)));
        chk("err_pulse",    80'(ep),   80'(m_pulse));
        chk("busy",         80'(bz),   80'(pend.size() != 0));
        chk("w8_word_cnt",  80'(wc8),  80'(satv(m_words, 8)));
        chk("w8_word_err",  80'(wec8), 80'(satv(m_werr, 8)));
        chk("w8_sym_err",   80'(sec8), 80'(satv(m_sym, 8)));
        chk("w8_bit_err",   80'(bec8), 80'(satv(m_bit, 8)));
        chk("w8_disp_det",  80'(ddc8), 80'(satv(m_disp, 8)));
        chk("w8_kin_det",   80'(kdc8), 80'(satv(m_kin, 8)));
        chk("w8_err_pulse", 80'(ep8),  80'(m_pulse));
        chk("w8_busy",      80'(bz8),  80'(pend.size() != 0));
`ifdef ERR_MON_CAPTURE_EN
        chk("first_vld",    80'(fv),   80'(m_cap_vld));
        chk("first_idx",    80'(fidx), 80'(satv(m_cap_idx, 32)));
        chk("first_diff",   fdiff,     m_cap_diff);
        chk("w8_first_vld", 80'(fv8),  80'(m_cap_vld));
        chk("w8_first_idx", 80'(fidx8), 80'(satv(m_cap_idx, 8)));
        chk("w8_first_diff", fdiff8,   m_cap_diff);
`endif
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks after the next rising edge.
    task automatic step(input bit e, input bit c, input logic [79:0] o, input logic [79:0] x, input logic [3:0] f);
        en = e; clear = c; d_orig = o; d_corr = x;
        {disp_o, disp_c, kin_o, kin_c} = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 4'd0);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1; en = 1'b0; clear = 1'b0;
        #1;
        model_flush();
        check_all();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [79:0] rnd_mask();
        logic [95:0] r;
        logic [79:0] m;
        r = {$urandom, $urandom, $urandom};
        m = '0;
        case ($urandom_range(0, 4))
            0, 1: m = '0;
            2:    m[$urandom_range(0, 79)] = 1'b1;
            3:    m[$urandom_range(0, 7) * 10 +: 10] = r[9:0];
            default: m = r[79:0];
        endcase
        return m;
    endfunction

    logic [79:0] ones;
    logic [95:0] rw;

    initial begin
        ones = '1;
        en = 0; clear = 0; d_orig = '0; d_corr = '0;
        disp_o = 0; disp_c = 0; kin_o = 0; kin_c = 0;
        rst = 1'b1;
        model_flush();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Equal zero words: counted, no errors.
        step(1'b1, 1'b0, '0, '0, 4'd0);
        idle(3);
        chk("eq_word_cnt", 80'(wc), 80'd1);
        chk("eq_bit_err", 80'(bec), 80'd0);

        // Single bit error: pulse only after the third edge.
        apply_reset(2);
        step(1'b1, 1'b0, '0, 80'h1, 4'd0);
        chk("one_pulse_n", 80'(ep), 80'd0);
        idle(1);
        chk("one_pulse_n1", 80'(ep), 80'd0);
        idle(1);
        chk("one_pulse_n2", 80'(ep), 80'd1);
        idle(1);
        chk("one_pulse_n3", 80'(ep), 80'd0);
        chk("one_bit_err", 80'(bec), 80'd1);
        chk("one_sym_err", 80'(sec), 80'd1);
        chk("one_word_err", 80'(wec), 80'd1);

        // Back-to-back all-ones diffs, then saturation of the 8-bit build.
        apply_reset(2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, ones, 4'd0);
        idle(3);
        chk("ones_bit_err", 80'(bec), 80'd240);
        chk("ones_sym_err", 80'(sec), 80'd24);
        chk("ones_word_err", 80'(wec), 80'd3);
        step(1'b1, 1'b0, '0, ones, 4'd0);
        idle(3);
        chk("sat8_bit_err", 80'(bec8), 80'd255);
        chk("sat8_word_cnt", 80'(wc8), 80'd4);
        chk("ones_bit_err4", 80'(bec), 80'd320);

        // Injected-flag detection only for corrupted=1, original=0.
        apply_reset(2);
        step(1'b1, 1'b0, '0, '0, 4'b0101);
        step(1'b1, 1'b0, '0, '0, 4'b1111);
        step(1'b1, 1'b0, '0, '0, 4'b1010);
        idle(3);
        chk("flag_disp", 80'(ddc), 80'd1);
        chk("flag_kin", 80'(kdc), 80'd1);

        // Clear right behind an erroneous word.
        apply_reset(2);
        step(1'b1, 1'b0, '0, ones, 4'd0);
        step(1'b0, 1'b1, '0, '0, 4'd0);
        chk("clr_bit_err", 80'(bec), 80'd0);
        idle(1);
        chk("clr_busy", 80'(bz), 80'd0);
        idle(2);
        chk("clr_word_err", 80'(wec), 80'd0);

        // Reset while words are in flight.
        step(1'b1, 1'b0, '0, ones, 4'd0);
        step(1'b1, 1'b0, '0, ones, 4'd0);
        apply_reset(1);
        idle(4);
        chk("midrst_word_cnt", 80'(wc), 80'd0);

`ifdef ERR_MON_CAPTURE_EN
        apply_reset(2);
        step(1'b1, 1'b0, '0, '0, 4'd0);
        step(1'b1, 1'b0, '0, 80'h300, 4'd0);
        step(1'b1, 1'b0, '0, 80'h5, 4'd0);
        idle(3);
        chk("cap_vld", 80'(fv), 80'd1);
        chk("cap_idx", 80'(fidx), 80'd1);
        chk("cap_diff", fdiff, 80'h300);
`endif

        // Random traffic with sparse clears and resets.
        apply_reset(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset($urandom_range(1, 2));
            end else begin
                rw = {$urandom, $urandom, $urandom};
                step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                     rw[79:0], rw[79:0] ^ rnd_mask(), 4'($urandom_range(0, 15)));
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
